// File: rtl/nrx_rom_loader.sv
// HPS ioctl download to game-core ROM write port, with core-reset sequencing around the download.
// Define NRX_ROM_LOADER_CHECKSUM_EN to build the additive byte checksum on SUM.
module nrx_rom_loader #(
    parameter int unsigned HOLD_CYC = 16,
    parameter logic [24:0] TOP_AD   = 25'h051FF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        DL,
    input  logic        WR,
    input  logic [24:0] AD,
    input  logic [7:0]  DT,
    output logic [15:0] ROMAD,
    output logic [7:0]  ROMDT,
    output logic        ROMEN,
    output logic [1:0]  REGION,
    output logic        CORE_RST,
    output logic        ERR,
    output logic [7:0]  SUM
);
    localparam int unsigned CW = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          dl_start;
    logic          accept;
    logic          in_range;
    logic [1:0]    region_dec;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // An aborted hold leaves cnt as-is; the next DL fall reloads it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dl_start  = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (DL) begin
                    state_nxt = LOAD;
                    dl_start  = 1'b1;
                end
            end
            LOAD: begin
                if (!DL) begin
                    if (HOLD_CYC == 0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = HOLD;
                        cnt_nxt   = CW'(HOLD_CYC);
                    end
                end
            end
            HOLD: begin
                if (DL) begin
                    state_nxt = LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CW'(1)) state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign CORE_RST = (state != RUN);
    assign accept   = WR && DL && (state == LOAD);
    assign in_range = (AD <= TOP_AD);

    always_comb begin
        if (AD < 25'h0004000)      region_dec = 2'd0;
        else if (AD < 25'h0005000) region_dec = 2'd1;
        else                       region_dec = 2'd2;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ROMAD  <= '0;
            ROMDT  <= '0;
            ROMEN  <= 1'b0;
            REGION <= '0;
            ERR    <= 1'b0;
        end else begin
            ROMEN <= accept && in_range;
            if (accept && in_range) begin
                ROMAD  <= AD[15:0];
                ROMDT  <= DT;
                REGION <= region_dec;
            end
            if (dl_start)
                ERR <= 1'b0;
            else if (accept && !in_range)
                ERR <= 1'b1;
        end
    end

`ifdef NRX_ROM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            sum_q <= '0;
        else if (dl_start)
            sum_q <= '0;
        else if (accept && in_range)
            sum_q <= sum_q + DT;
    end

    assign SUM = sum_q;
`else
    assign SUM = 8'h00;
`endif

endmodule

// File: tb/tb_nrx_rom_loader.sv
// Scoreboard bench for nrx_rom_loader: a stimulus-side reference model queues expected ROM writes,
// a negedge monitor pops and compares them and tracks ERR/REGION/SUM every cycle.
module tb_nrx_rom_loader;
    localparam int unsigned HOLD = 16;
    localparam logic [24:0] TOP  = 25'h051FF;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b1;
    logic        DL    = 1'b0;
    logic        WR    = 1'b0;
    logic [24:0] AD    = '0;
    logic [7:0]  DT    = '0;
    logic [15:0] ROMAD;
    logic [7:0]  ROMDT;
    logic        ROMEN;
    logic [1:0]  REGION;
    logic        CORE_RST;
    logic        ERR;
    logic [7:0]  SUM;

    nrx_rom_loader #(.HOLD_CYC(HOLD), .TOP_AD(TOP)) dut (
        .CLK(CLK), .RST_N(RST_N), .DL(DL), .WR(WR), .AD(AD), .DT(DT),
        .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN), .REGION(REGION),
        .CORE_RST(CORE_RST), .ERR(ERR), .SUM(SUM)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] ad;
        logic [7:0]  dt;
        logic [1:0]  rg;
        int          cyc;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic       prev_dl = 1'b0;
    int         low_run = 1000;
    logic [7:0] msum = '0;
    logic       merr = 1'b0;
    logic [1:0] mreg = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a byte is taken when DL was already high at the previous edge;
    // a DL rise starts a fresh download unless it lands inside the HOLD-cycle window after a fall.
    initial forever begin
        @(posedge CLK);
        cyc++;
        if (!RST_N) begin
            prev_dl = 1'b0;
            low_run = 1000;
            msum    = '0;
            merr    = 1'b0;
            mreg    = '0;
        end else begin
            if (WR && DL && prev_dl) begin
                if (AD <= TOP) begin
                    exp_t e;
                    int   page;
                    page = int'(AD) / 4096;
                    e.ad  = AD[15:0];
                    e.dt  = DT;
                    e.rg  = (page < 4) ? 2'd0 : (page == 4) ? 2'd1 : 2'd2;
                    e.cyc = cyc;
                    q.push_back(e);
                    mreg = e.rg;
                    msum = msum + DT;
                end else begin
                    merr = 1'b1;
                end
            end
            if (DL && !prev_dl && low_run > int'(HOLD)) begin
                msum = '0;
                merr = 1'b0;
            end
            low_run = DL ? 0 : ((low_run < 1000) ? low_run + 1 : 1000);
            prev_dl = DL;
        end
    end

    initial forever begin
        exp_t       e;
        logic [7:0] exp_sum;
        @(negedge CLK);
        if (ROMEN) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL romen_unexpected: got pulse ad=%0h dt=%0h expected none (cycle %0d)", ROMAD, ROMDT, cyc);
            end else begin
                e = q.pop_front();
                chk("romen_cycle", 32'(cyc), 32'(e.cyc));
                chk("romad", 32'(ROMAD), 32'(e.ad));
                chk("romdt", 32'(ROMDT), 32'(e.dt));
                chk("region_wr", 32'(REGION), 32'(e.rg));
            end
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL romen_missing: got none expected ad=%0h at cycle %0d", e.ad, e.cyc);
        end
`ifdef NRX_ROM_LOADER_CHECKSUM_EN
        exp_sum = msum;
`else
        exp_sum = 8'h00;
`endif
        chk("region", 32'(REGION), 32'(mreg));
        chk("err", 32'(ERR), 32'(merr));
        chk("sum", 32'(SUM), 32'(exp_sum));
    end

    task automatic drv(input logic dl, input logic wr, input logic [24:0] ad, input logic [7:0] dt);
        @(negedge CLK);
        DL = dl;
        WR = wr;
        AD = ad;
        DT = dt;
    endtask

    task automatic rnd_cyc(input logic dl);
        logic [24:0] a;
        case ($urandom_range(0, 3))
            0:       a = 25'($urandom_range(0, 32'h3FFF));
            1:       a = 25'($urandom_range(32'h4000, 32'h4FFF));
            2:       a = 25'($urandom_range(32'h5000, 32'(TOP)));
            default: a = 25'(32'(TOP) + 1 + $urandom_range(0, 32'h0FFFFF));
        endcase
        drv(dl, 1'($urandom_range(0, 1)), a, 8'($urandom));
    endtask

    task automatic hold_len(input string nm);
        int n;
        n = 0;
        drv(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (CORE_RST) n++;
            else break;
        end
        chk(nm, 32'(n), 32'(HOLD));
    endtask

    initial begin
        logic dl;
        #1 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_core_rst", 32'(CORE_RST), 32'd1);
        chk("rst_romen", 32'(ROMEN), 32'd0);
        chk("rst_romad", 32'(ROMAD), 32'd0);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_core_rst", 32'(CORE_RST), 32'd1);

        // first DL cycle is still IDLE: this strobe must be dropped
        drv(1'b1, 1'b1, 25'h0000100, 8'hEE);
        drv(1'b1, 1'b1, 25'h0000000, 8'h12);
        drv(1'b1, 1'b1, 25'h0004000, 8'h34);
        drv(1'b1, 1'b1, 25'h0005000, 8'h56);
        drv(1'b1, 1'b0, '0, '0);
        drv(1'b1, 1'b1, 25'h0005200, 8'h77);
        drv(1'b1, 1'b0, '0, '0);
        chk("oor_err", 32'(ERR), 32'd1);
        chk("oor_region", 32'(REGION), 32'd2);

        hold_len("hold_len_first");
        chk("run_core_rst", 32'(CORE_RST), 32'd0);

        drv(1'b1, 1'b0, '0, '0);
        drv(1'b1, 1'b0, '0, '0);
        chk("err_clr_new_dl", 32'(ERR), 32'd0);
        repeat (40) rnd_cyc(1'b1);

        // re-raise DL when the hold counter is at 5
        drv(1'b0, 1'b0, '0, '0);
        repeat (11) @(negedge CLK);
        drv(1'b1, 1'b0, '0, '0);
        drv(1'b1, 1'b0, '0, '0);
        chk("abort_core_rst", 32'(CORE_RST), 32'd1);
        repeat (10) rnd_cyc(1'b1);
        hold_len("hold_len_after_abort");

        // strobes in RUN with DL low are ignored
        drv(1'b0, 1'b1, 25'h0000100, 8'hAA);
        drv(1'b0, 1'b1, 25'h0004100, 8'hBB);
        drv(1'b0, 1'b0, '0, '0);

        // reset lands on the edge that would capture the second strobe
        drv(1'b1, 1'b0, '0, '0);
        drv(1'b1, 1'b1, 25'h0000010, 8'h99);
        drv(1'b1, 1'b1, 25'h0000020, 8'h55);
        #1 RST_N = 1'b0;
        @(negedge CLK);
        WR = 1'b0;
        chk("rst_romen_suppressed", 32'(ROMEN), 32'd0);
        RST_N = 1'b1;
        drv(1'b1, 1'b1, 25'h0000030, 8'h42);
        drv(1'b1, 1'b0, '0, '0);

        dl = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) dl = ~dl;
            rnd_cyc(dl);
        end

        drv(1'b0, 1'b0, '0, '0);
        repeat (30) @(negedge CLK);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
